fpu_req_arb: RTL

- Shares one FPU instance between NREQ requesters, e.g. an integer pipe and a vector/offload port.
- Grants requesters round-robin and holds each granted operation's op, operands and rounding modes stable on the FPU inputs until the FPU result handshake completes. The FPU steers its output handshake by the current op, so the op must stay stable until then.
- Routes the result and fflags back to the granted requester.
- Allows exactly one operation in flight at a time.

---
 rtl/fpu_req_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_req_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_req_arb                                                     |
// | Purpose  : Round-robin arbiter sharing one FPU between NREQ requesters.    |
// |            One operation in flight at a time; the granted payload is held  |
// |            on the FPU inputs until the FPU result handshake completes,     |
// |            and the result/fflags are routed back to the owner.            |
// | Ports    : i_clk/i_rst         clock, synchronous active-high reset       |
// |            i_req_* / o_req_*   per-requester request channel (packed)     |
// |            o_rsp_* / i_rsp_*   per-requester response channel             |
// |            o_fpu_* / i_fpu_*   FPU input/output handshakes and payload    |
// |            o_busy, o_owner     status: not idle, current grant index      |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module fpu_req_arb #(
  parameter int NREQ = 2,
  parameter int FLEN = 32,
  parameter int OPW  = 20,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  output logic [NREQ-1:0]        o_req_ready,
  input  logic [NREQ*3*FLEN-1:0] i_req_rs,
  input  logic [NREQ*OPW-1:0]    i_req_op,
  input  logic [NREQ*3-1:0]      i_req_rm_inst,
  input  logic [NREQ*3-1:0]      i_req_rm_fcsr,
  output logic [NREQ-1:0]        o_rsp_valid,
  input  logic [NREQ-1:0]        i_rsp_ready,
  output logic [FLEN-1:0]        o_rsp_result,
  output logic [4:0]             o_rsp_fflags,
  output logic [3*FLEN-1:0]      o_fpu_rs,
  output logic [OPW-1:0]         o_fpu_op,
  output logic [2:0]             o_fpu_rm_inst,
  output logic [2:0]             o_fpu_rm_fcsr,
  output logic                   o_fpu_in_valid,
  input  logic                   i_fpu_in_ready,
  input  logic                   i_fpu_out_valid,
  output logic                   o_fpu_out_ready,
  input  logic [FLEN-1:0]        i_fpu_result,
  input  logic [4:0]             i_fpu_fflags,
  output logic                   o_busy,
  output logic [IDW-1:0]         o_owner
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  // One extra bit so prio + offset never overflows before the wrap.
  localparam logic [IDW:0]    c_NREQ = NREQ[IDW:0];
  localparam logic [NREQ-1:0] c_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]        state_q,  state_d;
  logic [IDW-1:0]    owner_q,  owner_d;
  logic [IDW-1:0]    prio_q,   prio_d;
  logic [3*FLEN-1:0] rs_q,     rs_d;
  logic [OPW-1:0]    op_q,     op_d;
  logic [2:0]        rmi_q,    rmi_d;
  logic [2:0]        rmf_q,    rmf_d;
  logic [FLEN-1:0]   result_q, result_d;
  logic [4:0]        fflags_q, fflags_d;

  logic [3*FLEN-1:0] w_req_rs  [NREQ];
  logic [OPW-1:0]    w_req_op  [NREQ];
  logic [2:0]        w_req_rmi [NREQ];
  logic [2:0]        w_req_rmf [NREQ];

  logic              w_grant_found;
  logic [IDW-1:0]    w_grant_idx;
  logic [IDW:0]      w_scan;
  logic [IDW:0]      w_next;
  logic              w_accept;

  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign w_req_rs[r]  = i_req_rs[r*3*FLEN +: 3*FLEN];
    assign w_req_op[r]  = i_req_op[r*OPW +: OPW];
    assign w_req_rmi[r] = i_req_rm_inst[r*3 +: 3];
    assign w_req_rmf[r] = i_req_rm_fcsr[r*3 +: 3];
  end

  // Scan offsets from the far end down to 0 so that the last hit written,
  // which wins, is the one closest to prio in wraparound order.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_scan = {1'b0, prio_q} + i[IDW:0];
      if (w_scan >= c_NREQ) begin
        w_scan = w_scan - c_NREQ;
      end
      if (i_req_valid[w_scan[IDW-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan[IDW-1:0];
      end
    end
  end

  // Reset gates the accept so nothing is taken while the block is clearing.
  assign w_accept = (state_q == c_IDLE) && w_grant_found && !i_rst;
  assign w_next   = {1'b0, w_grant_idx} + {{IDW{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    rs_d     = rs_q;
    op_d     = op_q;
    rmi_d    = rmi_q;
    rmf_d    = rmf_q;
    result_d = result_q;
    fflags_d = fflags_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          owner_d = w_grant_idx;
          prio_d  = (w_next == c_NREQ) ? '0 : w_next[IDW-1:0];
          rs_d    = w_req_rs[w_grant_idx];
          op_d    = w_req_op[w_grant_idx];
          rmi_d   = w_req_rmi[w_grant_idx];
          rmf_d   = w_req_rmf[w_grant_idx];
          state_d = c_ISSUE;
        end
      end
      c_ISSUE: begin
        if (i_fpu_in_ready) begin
          // A combinational FPU can answer in the issue cycle itself.
          if (i_fpu_out_valid) begin
            result_d = i_fpu_result;
            fflags_d = i_fpu_fflags;
            state_d  = c_RESP;
          end else begin
            state_d  = c_WAIT;
          end
        end
      end
      c_WAIT: begin
        if (i_fpu_out_valid) begin
          result_d = i_fpu_result;
          fflags_d = i_fpu_fflags;
          state_d  = c_RESP;
        end
      end
      c_RESP: begin
        if (i_rsp_ready[owner_q]) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= c_IDLE;
      owner_q  <= '0;
      prio_q   <= '0;
      rs_q     <= '0;
      op_q     <= '0;
      rmi_q    <= '0;
      rmf_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      rs_q     <= rs_d;
      op_q     <= op_d;
      rmi_q    <= rmi_d;
      rmf_q    <= rmf_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign o_req_ready     = w_accept ? (c_ONE << w_grant_idx) : '0;
  assign o_rsp_valid     = (state_q == c_RESP) ? (c_ONE << owner_q) : '0;
  assign o_rsp_result    = result_q;
  assign o_rsp_fflags    = fflags_q;
  // The FPU steers its output by the op, so the payload stays registered.
  assign o_fpu_rs        = rs_q;
  assign o_fpu_op        = op_q;
  assign o_fpu_rm_inst   = rmi_q;
  assign o_fpu_rm_fcsr   = rmf_q;
  assign o_fpu_in_valid  = (state_q == c_ISSUE);
  assign o_fpu_out_ready = (state_q == c_ISSUE) || (state_q == c_WAIT);
  assign o_busy          = (state_q != c_IDLE);
  assign o_owner         = owner_q;

endmodule
`default_nettype wire
